// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial nibble adder: state encodings, nibble width
// and a helper that sizes the nibble index counter.
package serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The index counter needs at least one bit, even for a single-nibble operand.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 32'sd1) ? $clog2(nibbles) : 32'sd1;
  endfunction

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit ripple-carry adder built from full-adder cells.
// This is the single shared datapath driven by serial_add_ctrl.
module nibble_add
  import serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]           = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[NIBBLE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial WIDTH-bit adder: one nibble per clock through a shared nibble_add, LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` input for a - b (mod 2^WIDTH).
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [1:0]          state_r;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [IDX_W-1:0]    idx_r;
  logic                carry_r;
  logic [WIDTH-1:0]    sum_r;
  logic                cout_r;
  logic                busy_r;
  logic                done_r;

  logic [WIDTH-1:0]    b_in_s;
  logic                cin0_s;
  logic [NIBBLE_W-1:0] nib_a_s;
  logic [NIBBLE_W-1:0] nib_b_s;
  logic [NIBBLE_W-1:0] nib_sum_s;
  logic                nib_cout_s;

  // Operand conditioning at acceptance: subtraction is a + ~b + 1.
`ifdef SERIAL_ADD_SUB_EN
  assign b_in_s = b ^ {WIDTH{sub}};
  assign cin0_s = sub;
`else
  assign b_in_s = b;
  assign cin0_s = 1'b0;
`endif

  // Select the current nibble of each latched operand for the shared adder.
  always_comb begin
    nib_a_s = a_r[NIBBLE_W*idx_r +: NIBBLE_W];
    nib_b_s = b_r[NIBBLE_W*idx_r +: NIBBLE_W];
  end

  nibble_add u_nibble_add (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .s    (nib_sum_s),
    .cout (nib_cout_s)
  );

  // Sequencer: accept, step one nibble per cycle, then a single done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b_in_s;
            idx_r   <= '0;
            carry_r <= cin0_s;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_r[NIBBLE_W*idx_r +: NIBBLE_W] <= nib_sum_s;
          carry_r <= nib_cout_s;
          if (idx_r == IDX_LAST) begin
            cout_r  <= nib_cout_s;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=16 and WIDTH=4 instances).
// Subtraction vectors run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [3:0]  sum4;
  logic        cout4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_in),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .start (start4),
    .a     (a4),
    .b     (b4),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done on the 16-bit DUT, counting edges and busy drops.
  task automatic wait_done(output int cycles, output int busy_drop);
    cycles = 0;
    busy_drop = 0;
    while (!done && cycles < 20) begin
      if (!busy) busy_drop++;
      tick();
      cycles++;
    end
  endtask

  // One full 16-bit operation with the start pulse held for a single cycle.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vsub, input logic [15:0] exp_sum, input logic exp_cout);
    int cyc;
    int drop;
    a = va;
    b = vb;
    sub_in = vsub;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va;
    b = ~vb;
    wait_done(cyc, drop);
    check_eq({tag, "_latency"}, 32'(cyc), 32'd4);
    check_eq({tag, "_busy_run"}, 32'(drop), 32'd0);
    check_eq({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    check_eq({tag, "_sum"}, {16'd0, sum}, {16'd0, exp_sum});
    check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    tick();
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_sum_held"}, {16'd0, sum}, {16'd0, exp_sum});
  endtask

  initial begin
    int cyc;
    int drop;
    int seen_done;

    reset = 1'b1;
    start = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    sub_in = 1'b0;
    start4 = 1'b0;
    a4 = 4'h0;
    b4 = 4'h0;
    tick();
    tick();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_sum", {16'd0, sum}, 32'd0);
    check_eq("rst_cout", {31'd0, cout}, 32'd0);
    check_eq("rst_busy4", {31'd0, busy4}, 32'd0);
    reset = 1'b0;
    tick();

    run_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

    // Start held high across a whole op; operands changed mid-RUN.
    a = 16'hA5A5;
    b = 16'h0F0F;
    start = 1'b1;
    tick();
    tick();
    a = 16'h8000;
    b = 16'h8001;
    wait_done(cyc, drop);
    check_eq("t3_latency", 32'(cyc), 32'd3);
    check_eq("t3_sum1", {16'd0, sum}, 32'h0000B4B4);
    check_eq("t3_cout1", {31'd0, cout}, 32'd0);
    tick();
    check_eq("t3_gap_idle", {31'd0, busy}, 32'd0);
    tick();
    check_eq("t3_second_accept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(cyc, drop);
    check_eq("t3_latency2", 32'(cyc), 32'd4);
    check_eq("t3_sum2", {16'd0, sum}, 32'h00000001);
    check_eq("t3_cout2", {31'd0, cout}, 32'd1);
    tick();

    // Reset during the second RUN cycle discards the operation.
    a = 16'h0FFF;
    b = 16'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t4_busy", {31'd0, busy}, 32'd0);
    check_eq("t4_done", {31'd0, done}, 32'd0);
    check_eq("t4_sum", {16'd0, sum}, 32'd0);
    check_eq("t4_cout", {31'd0, cout}, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) seen_done++;
      tick();
    end
    check_eq("t4_no_done", 32'(seen_done), 32'd0);
    run_op("t4_after", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("t5_sub_a", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
    run_op("t5_sub_b", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
`endif

    // WIDTH=4 instance: single RUN cycle.
    a4 = 4'h9;
    b4 = 4'h8;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("t6_latency", 32'(cyc), 32'd1);
    check_eq("t6_sum", {28'd0, sum4}, 32'h1);
    check_eq("t6_cout", {31'd0, cout4}, 32'd1);
    check_eq("t6_busy", {31'd0, busy4}, 32'd1);
    tick();
    check_eq("t6_done_pulse", {31'd0, done4}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
